// File: rtl/icache_pkg.sv
// Shared types, widths and address-field helpers for the read-only instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALLOCATE = 2'd1,
        REFILL   = 2'd2
    } state_e;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int MEM_ADDR_W      = 28;
    localparam int ADDR_W          = 30;
    localparam int OFFSET_W        = 2;

    function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

    // Block address {tag,index}; index is its low INDEX_W bits, tag the rest.
    function automatic logic [MEM_ADDR_W-1:0] get_block(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_W];
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off);
        return blk[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: per-set valid bit, tag and 4-word block; combinational read, synchronous block write.
module icache_way_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               valid_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [BLOCK_W-1:0] data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [BLOCK_W-1:0] wr_data_i
);
    localparam int SETS = 2**INDEX_W;

    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [BLOCK_W-1:0] data_mem [SETS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag/data contents are don't-care until the valid bit is set, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_index_i]  <= wr_tag_i;
            data_mem[wr_index_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[rd_index_i];
    assign tag_o   = tag_mem[rd_index_i];
    assign data_o  = data_mem[rd_index_i];

endmodule

// File: rtl/icache_2way_ro.sv
// Read-only 2-way set-associative instruction cache: zero-latency hits, whole-block refill into the LRU way.
module icache_2way_ro
    import icache_pkg::*;
#(
    parameter int INDEX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  proc_read,
    input  logic                  proc_write,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [WORD_W-1:0]     proc_wdata,
    output logic                  proc_stall,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [BLOCK_W-1:0]    mem_wdata,
    input  logic [BLOCK_W-1:0]    mem_rdata,
    input  logic                  mem_ready
);
    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int SETS  = 2**INDEX_W;

    state_e                state_q, state_d;
    logic [MEM_ADDR_W-1:0] miss_addr_q;
    logic [SETS-1:0]       lru_q;

    logic [MEM_ADDR_W-1:0] req_block;
    logic [INDEX_W-1:0]    req_index, miss_index;
    logic [TAG_W-1:0]      req_tag, miss_tag;
    logic [1:0]            way_valid, way_hit, way_wr_en;
    logic [TAG_W-1:0]      way_tag  [2];
    logic [BLOCK_W-1:0]    way_data [2];
    logic                  req, hit, miss, hit_way, fill, victim;
    logic                  unused_write_port;

    assign req_block  = get_block(proc_addr);
    assign req_index  = req_block[INDEX_W-1:0];
    assign req_tag    = req_block[MEM_ADDR_W-1:INDEX_W];
    assign miss_index = miss_addr_q[INDEX_W-1:0];
    assign miss_tag   = miss_addr_q[MEM_ADDR_W-1:INDEX_W];

    // Lookups only count in IDLE; the reset gate keeps a held request from stalling during reset.
    assign req    = proc_read && rst_n && (state_q == IDLE);
    assign fill   = (state_q == ALLOCATE) && mem_ready;
    assign victim = lru_q[miss_index];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            icache_way_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way (
                .clk        (clk),
                .rst_n      (rst_n),
                .rd_index_i (req_index),
                .valid_o    (way_valid[gi]),
                .tag_o      (way_tag[gi]),
                .data_o     (way_data[gi]),
                .wr_en_i    (way_wr_en[gi]),
                .wr_index_i (miss_index),
                .wr_tag_i   (miss_tag),
                .wr_data_i  (mem_rdata)
            );
            assign way_hit[gi]   = way_valid[gi] && (way_tag[gi] == req_tag);
            assign way_wr_en[gi] = fill && (victim == 1'(gi));
        end
    endgenerate

    assign hit     = req && (|way_hit);
    assign miss    = req && !(|way_hit);
    assign hit_way = way_hit[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lru_q       <= '0;
            miss_addr_q <= '0;
        end else begin
            if (fill) begin
                lru_q[miss_index] <= ~victim;
            end else if (hit) begin
                lru_q[req_index] <= ~hit_way;
            end
            if (miss) begin
                miss_addr_q <= req_block;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (miss) state_d = ALLOCATE;
            ALLOCATE: if (mem_ready) state_d = REFILL;
            REFILL:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read   = (state_q == ALLOCATE);
        proc_stall = (state_q != IDLE) || miss;
        proc_rdata = '0;
        if (hit) begin
            proc_rdata = get_word(hit_way ? way_data[1] : way_data[0], get_offset(proc_addr));
        end
    end

    assign mem_addr  = miss_addr_q;
    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    assign unused_write_port = ^{proc_write, proc_wdata};

endmodule

// File: tb/tb_icache_2way_ro.sv
// Scoreboard bench for icache_2way_ro: a latency-4 block memory model plus expected-word and expected-block queues.
module tb_icache_2way_ro;
    import icache_pkg::*;

    localparam int LAT = 4;
    localparam int MISS_STALL = LAT + 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  proc_read = 1'b0;
    logic                  proc_write = 1'b0;
    logic [ADDR_W-1:0]     proc_addr = '0;
    logic [WORD_W-1:0]     proc_wdata = '0;
    logic                  proc_stall;
    logic [WORD_W-1:0]     proc_rdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [BLOCK_W-1:0]    mem_wdata;
    logic [BLOCK_W-1:0]    mem_rdata = '0;
    logic                  mem_ready;
    logic                  resp_ready = 1'b0;
    logic                  force_ready = 1'b0;
    logic                  mem_en = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int mem_rd_cycles = 0;
    int lat_cnt = 0;

    logic [WORD_W-1:0]     exp_q[$];
    logic [MEM_ADDR_W-1:0] exp_blk_q[$];

    assign mem_ready = resp_ready | force_ready;

    always #5 clk = ~clk;

    icache_2way_ro #(.INDEX_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    // Memory image: word k of block b is b*0x100 + k*0x11 (block 0 = 0x00,0x11,0x22,0x33).
    function automatic logic [WORD_W-1:0] mem_word(input logic [MEM_ADDR_W-1:0] blk, input int k);
        return WORD_W'((32'(blk) << 8) + 32'(k * 17));
    endfunction

    function automatic logic [BLOCK_W-1:0] block_data(input logic [MEM_ADDR_W-1:0] blk);
        logic [BLOCK_W-1:0] b;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) b[k*WORD_W +: WORD_W] = mem_word(blk, k);
        return b;
    endfunction

    function automatic logic [WORD_W-1:0] exp_word(input logic [ADDR_W-1:0] addr);
        return mem_word(addr[ADDR_W-1:2], int'(addr[1:0]));
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Memory responder: checks the requested block address every cycle and answers on the LAT-th cycle.
    always @(negedge clk) begin
        resp_ready = 1'b0;
        if (mem_read && rst_n) begin
            mem_rd_cycles++;
            if (exp_blk_q.size() == 0) begin
                check_eq("mem_read_unexpected", 1, 0);
            end else begin
                check_eq("mem_addr", mem_addr, exp_blk_q[0]);
                if (mem_en) begin
                    lat_cnt++;
                    if (lat_cnt == LAT) begin
                        resp_ready = 1'b1;
                        mem_rdata  = block_data(exp_blk_q[0]);
                        void'(exp_blk_q.pop_front());
                        lat_cnt = 0;
                    end
                end
            end
        end else begin
            lat_cnt = 0;
        end
    end

    task automatic fetch(input string tag, input logic [ADDR_W-1:0] addr, input int exp_stalls);
        int stalls;
        logic [WORD_W-1:0] exp;
        @(negedge clk);
        proc_read = 1'b1;
        proc_write = 1'b0;
        proc_addr = addr;
        exp_q.push_back(exp_word(addr));
        if (exp_stalls > 0) exp_blk_q.push_back(addr[ADDR_W-1:2]);
        stalls = 0;
        #1;
        while (proc_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check_eq({tag, "_stall"}, 32'(stalls), 32'(exp_stalls));
        exp = exp_q.pop_front();
        check_eq({tag, "_rdata"}, proc_rdata, exp);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        proc_read = 1'b0;
        #1;
        check_eq({tag, "_stall"}, proc_stall, 0);
        check_eq({tag, "_rdata"}, proc_rdata, 0);
    endtask

    initial begin
        int base;
        int stalls;
        logic [WORD_W-1:0] exp;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_stall", proc_stall, 0);
        check_eq("rst_rdata", proc_rdata, 0);
        check_eq("rst_mem_read", mem_read, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        base = mem_rd_cycles;
        fetch("cold_miss_0x2", 30'h2, MISS_STALL);
        check_eq("cold_mem_rd_cycles", 32'(mem_rd_cycles - base), LAT);

        base = mem_rd_cycles;
        fetch("hit_0x0", 30'h0, 0);
        fetch("hit_0x1", 30'h1, 0);
        fetch("hit_0x3", 30'h3, 0);
        check_eq("hits_no_mem_read", 32'(mem_rd_cycles - base), 0);
        idle_check("idle_after_hits");

        fetch("fill_B_0x10", 30'h10, MISS_STALL);
        fetch("hit_B_0x10", 30'h10, 0);
        fetch("touch_A_0x0", 30'h0, 0);
        fetch("fill_C_0x20", 30'h20, MISS_STALL);
        fetch("A_kept_0x0", 30'h0, 0);
        fetch("B_evicted_0x10", 30'h10, MISS_STALL);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            proc_read = 1'b0;
            proc_write = 1'b1;
            proc_addr = 30'h1;
            proc_wdata = 32'hDEAD_BEEF;
            #1;
            check_eq("wr_ignored_stall", proc_stall, 0);
            check_eq("wr_ignored_mem_write", mem_write, 0);
            check_eq("wr_ignored_mem_read", mem_read, 0);
        end
        proc_write = 1'b0;
        fetch("after_wr_0x1", 30'h1, 0);

        // Reset during ALLOCATE with memory held off; a mem_ready during reset must be ignored.
        @(negedge clk);
        mem_en = 1'b0;
        proc_read = 1'b1;
        proc_addr = 30'h44;
        exp_blk_q.push_back(28'h11);
        repeat (2) @(negedge clk);
        #1;
        check_eq("alloc_mem_read", mem_read, 1);
        check_eq("alloc_stall", proc_stall, 1);
        @(negedge clk);
        rst_n = 1'b0;
        force_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midrst_mem_read", mem_read, 0);
        check_eq("midrst_stall", proc_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        force_ready = 1'b0;
        proc_read = 1'b0;
        exp_blk_q.delete();
        mem_en = 1'b1;

        // Re-read of 0x0 misses after reset; address switches to 0x40 during ALLOCATE.
        base = mem_rd_cycles;
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h0;
        exp_blk_q.push_back(28'h0);
        exp_blk_q.push_back(28'h10);
        exp_q.push_back(exp_word(30'h40));
        stalls = 0;
        #1;
        while (proc_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            if (stalls == 1) proc_addr = 30'h40;
            #1;
        end
        check_eq("addr_change_stall", 32'(stalls), 32'(2 * MISS_STALL));
        exp = exp_q.pop_front();
        check_eq("addr_change_rdata", proc_rdata, exp);
        check_eq("addr_change_mem_rd_cycles", 32'(mem_rd_cycles - base), 2 * LAT);
        check_eq("addr_change_blk_q_empty", 32'(exp_blk_q.size()), 0);
        fetch("refilled_0x0", 30'h0, 0);
        fetch("refilled_0x40", 30'h40, 0);

        // Stray mem_ready while IDLE.
        @(negedge clk);
        proc_read = 1'b0;
        force_ready = 1'b1;
        @(negedge clk);
        force_ready = 1'b0;
        #1;
        check_eq("idle_ready_stall", proc_stall, 0);
        check_eq("idle_ready_mem_read", mem_read, 0);
        fetch("after_idle_ready_0x43", 30'h43, 0);
        idle_check("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

endmodule
